// File: rtl/md_pkg.sv
// Shared op codes, state type and default latencies for the multiply/divide unit.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_t;

   function automatic logic is_start(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide result ({hi,lo}) plus divide-by-zero flag.
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] divisor;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] sq;
   logic [31:0] sr;

   assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u  = {32'd0, a} * {32'd0, b};
   assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
   // Keep the divider free of X when b is zero; the result is discarded anyway.
   assign divisor = (b == 32'd0) ? 32'd1 : b;
   assign abs_a   = a[31] ? (32'd0 - a) : a;
   assign abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
   assign sq      = abs_a / abs_b;
   assign sr      = abs_a % abs_b;

   // Select the result for the requested operation.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op)
         MD_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV: begin
            // Quotient truncates toward zero; remainder follows the dividend sign.
            res_lo = (a[31] ^ divisor[31]) ? (32'd0 - sq) : sq;
            res_hi = a[31] ? (32'd0 - sr) : sr;
         end
         MD_DIVU: begin
            res_lo = a / divisor;
            res_hi = a % divisor;
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, holds busy for a fixed
// latency per op and raises the D-stage stall request.
module muldiv_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   md_state_t   state;
   logic [CW-1:0] cnt;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_zero;
   logic [31:0] ar_hi;
   logic [31:0] ar_lo;
   logic        ar_zero;

   md_arith u_arith (
      .op       (op),
      .a        (a),
      .b        (b),
      .res_hi   (ar_hi),
      .res_lo   (ar_lo),
      .div_zero (ar_zero)
   );

   assign stall = d_is_md & (busy | (req & is_start(op)));

   // Issue/run state machine with HI/LO ownership.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         res_hi   <= 32'd0;
         res_lo   <= 32'd0;
         res_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  case (op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        res_hi   <= ar_hi;
                        res_lo   <= ar_lo;
                        res_zero <= ar_zero;
                        cnt      <= ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                        busy     <= 1'b1;
                        state    <= RUN;
                     end
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // Requests arriving here violate the stall protocol and are ignored.
               if (cnt == CNT_ONE) begin
                  if (!res_zero) begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed HI/LO values.
module tb_muldiv_ctrl;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_is_md;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   int viol_cnt = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .op      (op),
      .a       (a),
      .b       (b),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // Protocol monitor: a request sampled while busy is a violation.
   always @(posedge clk) begin
      if (!reset && busy && req) viol_cnt <= viol_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one start op, follow it through busy and check the commit.
   task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input int exp_n, input logic [31:0] eh, input logic [31:0] el,
                         input string tag);
      int  n;
      bit  done;
      bit  stall_bad;
      bit  early;
      @(negedge clk);
      req = 1'b1; op = o; a = xa; b = xb; d_is_md = 1'b1;
      #1;
      check_val({tag, "_issue_stall"}, stall, 1'b1);
      check_val({tag, "_issue_busy"}, busy, 1'b0);
      @(negedge clk);
      req = 1'b0;
      n = 0; done = 1'b0; stall_bad = 1'b0; early = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (busy) begin
            n++;
            if (stall !== 1'b1) stall_bad = 1'b1;
            if (hi !== m_hi || lo !== m_lo) early = 1'b1;
            @(negedge clk);
         end else begin
            done = 1'b1;
         end
      end
      check_val({tag, "_done"}, done, 1'b1);
      check_val({tag, "_cycles"}, n, exp_n);
      check_val({tag, "_stall_busy"}, stall_bad, 1'b0);
      check_val({tag, "_no_early"}, early, 1'b0);
      m_hi = eh; m_lo = el;
      check_val({tag, "_hi"}, hi, eh);
      check_val({tag, "_lo"}, lo, el);
   endtask

   initial begin
      bit nonzero;
      reset = 1'b1; req = 1'b0; op = MD_MULT; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_hi", hi, 32'd0);
      check_val("rst_lo", lo, 32'd0);
      check_val("rst_stall", stall, 1'b0);
      reset = 1'b0;

      run_op(MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
      run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, "multu");
      run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
      run_op(MD_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu_zero");
      run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
      run_op(MD_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14,       "divu");
      run_op(MD_MULT,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");

      // MTHI then MTLO on consecutive cycles, no busy period.
      @(negedge clk);
      req = 1'b1; op = MD_MTHI; a = 32'h12345678; d_is_md = 1'b0;
      @(negedge clk);
      check_val("mthi_hi", hi, 32'h12345678);
      check_val("mthi_busy", busy, 1'b0);
      op = MD_MTLO; a = 32'h9ABCDEF0;
      @(negedge clk);
      req = 1'b0;
      check_val("mtlo_lo", lo, 32'h9ABCDEF0);
      check_val("mtlo_hi", hi, 32'h12345678);
      check_val("mtlo_busy", busy, 1'b0);

      // Stall only when the D stage holds an M/D op.
      @(negedge clk);
      req = 1'b1; op = MD_MULT; a = 32'd2; b = 32'd2; d_is_md = 1'b0;
      @(negedge clk);
      req = 1'b0;
      check_val("nostall_busy", busy, 1'b1);
      check_val("nostall_stall", stall, 1'b0);
      repeat (6) @(negedge clk);
      check_val("nostall_lo", lo, 32'd4);

      // Reset during busy cycle 4 of a DIV.
      req = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7; d_is_md = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rstrun_busy_pre", busy, 1'b1);
      reset = 1'b1;
      #1;
      check_val("rstrun_busy", busy, 1'b0);
      check_val("rstrun_hi", hi, 32'd0);
      check_val("rstrun_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      nonzero = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) nonzero = 1'b1;
      end
      check_val("rstrun_no_commit", nonzero, 1'b0);
      m_hi = 32'd0; m_lo = 32'd0;

      // Request held during busy must be ignored.
      req = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4; d_is_md = 1'b1;
      @(negedge clk);
      a = 32'd5; b = 32'd6;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      req = 1'b0;
      check_val("hold_busy_end", busy, 1'b0);
      check_val("hold_hi", hi, 32'd0);
      check_val("hold_lo", lo, 32'd12);
      repeat (3) @(negedge clk);
      check_val("hold_lo_stable", lo, 32'd12);
      check_val("hold_violations", viol_cnt, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers. It holds a busy state for a fixed latency per operation and drives the stall request that the hazard unit ORs into its D-stage freeze. It instantiates inside the CPU top next to the ALU.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU (≥1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  1  E-stage valid for an M/D-class instruction; qualifies op.
- op  in  3  operation code (package constants).
- a  in  32  rs operand (forwarded value).
- b  in  32  rt operand (forwarded value).
- d_is_md  in  1  the D-stage instruction is any M/D-class op, including MFHI/MFLO.
- busy  out  1  unit is executing a multi-cycle op.
- stall  out  1  combinational: d_is_md & (busy | (req & op is MULT/MULTU/DIV/DIVU)).
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN. Down-counter cnt, width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE with req and a start op (MULT, MULTU, DIV, DIVU):
  - Compute the 64-bit result from a and b and latch it into res_hi/res_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, then go to RUN.
- RUN: decrement cnt each cycle. When cnt==1, commit res_hi→hi and res_lo→lo, then go to IDLE.
- MTHI/MTLO in IDLE with req: write a to hi or lo at that edge. There is no busy period.
- MFHI/MFLO are not ops of this block. The datapath reads hi/lo directly, and the hazard unit guarantees they are never read while busy.
- req while in RUN is a protocol violation (stall prevents it). The request is ignored and the state is unchanged. The bench flags it as an assertion.
- MULT: {hi,lo} = signed a × signed b. MULTU: unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
- Division by zero (DIV/DIVU with b==0): full busy period still runs, then hi/lo are left unchanged at commit.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Invalid op codes: ignored.

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, cnt=0. stall reduces to d_is_md & req-start, which is 0 when there is no req.
- A start sampled at edge k gives busy=1 from after edge k until edge k+N (N = op latency). New hi/lo are visible after edge k+N, the same edge at which busy falls.
- stall is asserted in the issue cycle itself (via the req term) and for all N busy cycles.
- Back-to-back issue: a new start is accepted at edge k+N+1 at the earliest, i.e. one idle cycle after busy falls.
- MTHI/MTLO: hi/lo are updated at the sampling edge. Single-cycle.
- Reset asserted mid-RUN: state returns to IDLE immediately and busy, hi and lo go to 0. The pending result is discarded and never committed after reset releases.

## Structure
- Shared package md_pkg holds:
  - op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5;
  - state typedef {IDLE, RUN};
  - default latency constants.
- Optional sub-module md_arith: purely combinational 64-bit result from op, a and b, including the div-by-zero flag. The FSM, counter and HI/LO registers stay in muldiv_ctrl.

## Test plan
- MULT, a=0xFFFFFFFE (−2), b=3 → busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall=1 throughout with d_is_md=1.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 → 10 busy cycles, hi/lo unchanged.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated at each edge, busy never asserts.
- Start DIV, assert reset at busy cycle 4 → busy=0, hi=lo=0 immediately. After release, no commit occurs within the next 10 cycles.
- Issue MULT, then hold req with MULT during busy → second request ignored, result equals first op only; assertion fires.
